// File: rtl/word_unpack_pkg.sv
// Shared constants for the word unpacker: the stream word width and the
// lane-index width rule.
package word_unpack_pkg;

   localparam int WORD_W = 64;

   // A single-lane configuration still needs a 1-bit index register.
   function automatic int lidx_width(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/word_unpack.sv
// Splits each accepted 64-bit word into WORD_W/ELEM_W elements.
// Emits one element per transfer and marks the stream's final element.
module word_unpack
   import word_unpack_pkg::*;
#(
   parameter int ELEM_W    = 16,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       in,
   input  logic              in_isReady,
   output logic              in_canReceive,
   input  logic              in_isLast,
   output logic [ELEM_W-1:0] out,
   output logic              out_isReady,
   input  logic              out_canReceive,
   output logic              out_isLast
);

   localparam int LANES  = WORD_W / ELEM_W;
   localparam int LIDX_W = lidx_width(LANES);
   localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

   // Valid/ready rule: a transfer is a cycle with isReady high, and isReady
   // is only ever raised while the matching canReceive is high.

   logic [WORD_W-1:0] word;
   logic              full;
   logic [LIDX_W-1:0] lidx;
   logic              word_is_last;

   logic [LIDX_W-1:0] sel;
   logic              drain;

   always_comb begin
      sel           = LSB_FIRST ? lidx : (LAST_LANE - lidx);
      out           = word[int'(sel) * ELEM_W +: ELEM_W];
      out_isReady   = full & out_canReceive;
      drain         = out_isReady & (lidx == LAST_LANE);
      out_isLast    = drain & word_is_last;
      // Outputs depend only on state and out_canReceive, never on in_*.
      in_canReceive = ~full | drain;
   end

   // Accept has priority so a drain and a new word can share one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         word         <= '0;
         full         <= 1'b0;
         lidx         <= '0;
         word_is_last <= 1'b0;
      end else if (in_isReady) begin
         word         <= in;
         word_is_last <= in_isLast;
         full         <= 1'b1;
         lidx         <= '0;
      end else if (drain) begin
         full <= 1'b0;
         lidx <= '0;
      end else if (out_isReady) begin
         lidx <= lidx + 1'b1;
      end
   end

endmodule

// File: tb/tb_word_unpack.sv
// Bench for word_unpack: two instances (LSB-first and MSB-first) share one
// stimulus stream and are checked against per-order element queues.
module tb_word_unpack;

   logic        clk;
   logic        rst;
   logic [63:0] in;
   logic        in_isReady;
   logic        in_isLast;
   logic        out_canReceive;

   logic [15:0] out_a, out_b;
   logic        icr_a, icr_b;
   logic        ordy_a, ordy_b;
   logic        olast_a, olast_b;

   int vec_count  = 0;
   int miscompare = 0;

   // Expected elements; bit 16 flags the stream's final element.
   logic [16:0] exp_lsb_q[$];
   logic [16:0] exp_msb_q[$];
   logic [63:0] pend_w[$];
   logic        pend_l[$];

   int n_in_last  = 0;
   int n_out_last = 0;
   int n_out      = 0;

   word_unpack #(.ELEM_W(16), .LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .rst(rst), .in(in), .in_isReady(in_isReady),
      .in_canReceive(icr_a), .in_isLast(in_isLast), .out(out_a),
      .out_isReady(ordy_a), .out_canReceive(out_canReceive),
      .out_isLast(olast_a)
   );

   word_unpack #(.ELEM_W(16), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst(rst), .in(in), .in_isReady(in_isReady),
      .in_canReceive(icr_b), .in_isLast(in_isLast), .out(out_b),
      .out_isReady(ordy_b), .out_canReceive(out_canReceive),
      .out_isLast(olast_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      vec_count++;
      if (got !== exp) begin
         miscompare++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_word(input logic [63:0] w, input logic last);
      pend_w.push_back(w);
      pend_l.push_back(last);
   endtask

   // One clock cycle: drive, check combinational outputs against the queue
   // model, then update the model with this cycle's transfers.
   task automatic step(input bit want, input bit ocr, input bit do_rst);
      logic        exp_icr, exp_ordy;
      logic [16:0] ea, eb;
      logic [63:0] w;
      @(negedge clk);
      rst            = do_rst;
      out_canReceive = ocr;
      in_isReady     = 1'b0;
      if (pend_w.size() > 0) begin
         in        = pend_w[0];
         in_isLast = pend_l[0];
      end else begin
         in        = 64'($urandom) << 32 | 64'($urandom);
         in_isLast = 1'($urandom);
      end
      #1;
      exp_icr  = (exp_lsb_q.size() == 0) || (exp_lsb_q.size() == 1 && ocr);
      exp_ordy = (exp_lsb_q.size() > 0) && ocr;
      check_eq("in_canReceive_lsb", 64'(icr_a), 64'(exp_icr));
      check_eq("in_canReceive_msb", 64'(icr_b), 64'(exp_icr));
      if (want && !do_rst && pend_w.size() > 0 && exp_icr) in_isReady = 1'b1;
      #1;
      check_eq("out_isReady_lsb", 64'(ordy_a), 64'(exp_ordy));
      check_eq("out_isReady_msb", 64'(ordy_b), 64'(exp_ordy));
      if (exp_ordy) begin
         ea = exp_lsb_q.pop_front();
         eb = exp_msb_q.pop_front();
         check_eq("out_lsb", 64'(out_a), 64'(ea[15:0]));
         check_eq("out_msb", 64'(out_b), 64'(eb[15:0]));
         check_eq("out_isLast_lsb", 64'(olast_a), 64'(ea[16]));
         check_eq("out_isLast_msb", 64'(olast_b), 64'(eb[16]));
         n_out++;
      end else begin
         check_eq("out_isLast_idle", 64'({olast_a, olast_b}), 64'd0);
      end
      if (olast_a) n_out_last++;
      if (do_rst) begin
         exp_lsb_q.delete();
         exp_msb_q.delete();
      end
      if (in_isReady) begin
         w = pend_w.pop_front();
         if (pend_l.pop_front()) n_in_last++;
         for (int i = 0; i < 4; i++) begin
            exp_lsb_q.push_back({(in_isLast && i == 3), w[16*i +: 16]});
            exp_msb_q.push_back({(in_isLast && i == 3), w[16*(3-i) +: 16]});
         end
      end
   endtask

   task automatic drain_all(input int budget);
      int n = 0;
      while ((pend_w.size() > 0 || exp_lsb_q.size() > 0) && n < budget) begin
         step(1'b1, 1'b1, 1'b0);
         n++;
      end
      check_eq("drain_timeout", 64'(n >= budget), 64'd0);
   endtask

   logic [63:0] word_a;
   int          out_before;

   initial begin
      rst = 1'b1; in = '0; in_isReady = 1'b0; in_isLast = 1'b0;
      out_canReceive = 1'b0;
      word_a = 64'h0004_0003_0002_0001;

      // Reset, then idle.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check_eq("reset_out_lsb", 64'(out_a), 64'd0);
      check_eq("reset_out_msb", 64'(out_b), 64'd0);
      check_eq("reset_icr", 64'(icr_a), 64'd1);

      // Single word, both element orders, isLast on the final element.
      push_word(word_a, 1'b1);
      drain_all(20);
      check_eq("single_last_cnt", 64'(n_out_last), 64'd1);

      // Back-to-back words: 8 elements in 8 consecutive cycles.
      push_word(word_a, 1'b0);
      push_word(64'h1111_2222_3333_4444, 1'b1);
      out_before = n_out;
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0);
      check_eq("b2b_elements", 64'(n_out - out_before), 64'd8);
      drain_all(20);

      // Consumer stall after element 1: output and index must hold.
      push_word(word_a, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0);
         check_eq("stall_out_lsb", 64'(out_a), 64'h0002);
         check_eq("stall_out_msb", 64'(out_b), 64'h0003);
         check_eq("stall_icr", 64'(icr_a), 64'd0);
      end
      drain_all(20);

      // Reset while a word is held discards the rest of it.
      push_word(64'hdead_beef_cafe_f00d, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check_eq("post_rst_ordy", 64'(ordy_a), 64'd0);
      check_eq("post_rst_out", 64'(out_a), 64'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);

      // Randomised traffic over 200 words.
      n_in_last  = 0;
      n_out_last = 0;
      for (int i = 0; i < 200; i++)
         push_word({$urandom, $urandom}, ($urandom_range(0, 7) == 0));
      for (int n = 0; n < 6000 && (pend_w.size() > 0 || exp_lsb_q.size() > 0); n++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'b0);
      check_eq("random_timeout", 64'(pend_w.size() + exp_lsb_q.size()), 64'd0);
      check_eq("random_last_cnt", 64'(n_out_last), 64'(n_in_last));

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
      $finish;
   end

endmodule
